// File: rtl/data_mem_responder.sv
// Data-memory responder: single-ported byte-lane-writable word RAM with fixed access latency.
// Optional DMEM_ERR_EN adds an error flag for out-of-range addresses and empty-mask stores.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic        we_re,
  input  logic [3:0]  mask,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic        valid,
  output logic        data_valid,
  output logic [31:0] data_out
`ifdef DMEM_ERR_EN
  ,
  output logic        error
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               dvalid_q, dvalid_d;
  logic [31:0]        dout_q, dout_d;
  logic               we_q, we_d;
  logic [3:0]         mask_q, mask_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               err_q, err_d;

  logic [31:0]        mem_q [DEPTH];

  logic               in_idle_c;
  logic               cur_we_c;
  logic [3:0]         cur_mask_c;
  logic [IDX_W-1:0]   cur_idx_c;
  logic [31:0]        cur_wdata_c;
  logic               cur_err_c;
  logic               req_err_c;
  logic               enter_resp_c;
  logic               wr_en_c;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{address[1:0], address[31:IDX_W+2]};

`ifdef DMEM_ERR_EN
  logic error_q, error_d;
  assign req_err_c = (address[31:IDX_W+2] != '0) || (we_re && (mask == 4'h0));
  assign error     = error_q;
`else
  assign req_err_c = 1'b0;
`endif

  // With LATENCY=1 the access completes on the accepting edge, so use live inputs in IDLE.
  assign in_idle_c   = (state_q == S_IDLE);
  assign cur_we_c    = in_idle_c ? we_re                  : we_q;
  assign cur_mask_c  = in_idle_c ? mask                   : mask_q;
  assign cur_idx_c   = in_idle_c ? address[IDX_W+1:2]     : idx_q;
  assign cur_wdata_c = in_idle_c ? data_in                : wdata_q;
  assign cur_err_c   = in_idle_c ? req_err_c              : err_q;

  assign valid      = valid_q;
  assign data_valid = dvalid_q;
  assign data_out   = dout_q;

  // Next-state, capture and response logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    dvalid_d     = 1'b0;
    dout_d       = '0;
    we_d         = we_q;
    mask_d       = mask_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    enter_resp_c = 1'b0;
    wr_en_c      = 1'b0;
`ifdef DMEM_ERR_EN
    error_d      = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        valid_d = 1'b1;
        if (valid_q && request) begin
          we_d    = we_re;
          mask_d  = mask;
          idx_d   = address[IDX_W+1:2];
          wdata_d = data_in;
          err_d   = req_err_c;
          valid_d = 1'b0;
          if (LATENCY > 1) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end else begin
            state_d      = S_RESP;
            enter_resp_c = 1'b1;
          end
        end
      end
      S_WAIT: begin
        valid_d = 1'b0;
        if (cnt_q == CNT_W'(1)) begin
          state_d      = S_RESP;
          cnt_d        = '0;
          enter_resp_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        valid_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (enter_resp_c) begin
      dvalid_d = 1'b1;
      wr_en_c  = cur_we_c && !cur_err_c;
      if (!cur_we_c && !cur_err_c) begin
        dout_d = mem_q[cur_idx_c];
      end
`ifdef DMEM_ERR_EN
      error_d = cur_err_c;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      dvalid_q <= 1'b0;
      dout_q   <= '0;
      we_q     <= 1'b0;
      mask_q   <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef DMEM_ERR_EN
      error_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      dvalid_q <= dvalid_d;
      dout_q   <= dout_d;
      we_q     <= we_d;
      mask_q   <= mask_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
`ifdef DMEM_ERR_EN
      error_q  <= error_d;
`endif
    end
  end

  // RAM is never cleared; reset only suppresses the pending write.
  always_ff @(posedge clk) begin
    if (rst && wr_en_c) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_mask_c[i]) begin
          mem_q[cur_idx_c][8*i +: 8] <= cur_wdata_c[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: randomized loads/stores against a word-array reference model.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        request = 1'b0;
  logic        we_re = 1'b0;
  logic [3:0]  mask = 4'h0;
  logic [31:0] address = '0;
  logic [31:0] data_in = '0;
  logic        valid;
  logic        data_valid;
  logic [31:0] data_out;
`ifdef DMEM_ERR_EN
  logic        error;
`endif

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .request    (request),
    .we_re      (we_re),
    .mask       (mask),
    .address    (address),
    .data_in    (data_in),
    .valid      (valid),
    .data_valid (data_valid),
    .data_out   (data_out)
`ifdef DMEM_ERR_EN
    ,
    .error      (error)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        we;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned dv_cyc;
  } req_t;

  req_t        exp_q[$];
  logic [31:0] model [int];
  bit          mon_en = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic bit req_err(req_t r);
`ifdef DMEM_ERR_EN
    return ((r.addr >> 2) >= DEPTH) || (r.we && (r.mask == 4'h0));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int word_of(logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // Monitor: retire the oldest request whenever a completion pulse appears.
  always @(negedge clk) begin : monitor
    req_t        r;
    bit          e;
    int          w;
    logic [31:0] exp_d;
    logic [31:0] cur;
    if (mon_en) begin
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_dv", 32'(data_valid), 32'd0);
        end else begin
          r = exp_q.pop_front();
          e = req_err(r);
          w = word_of(r.addr);
          chk("dv_cycle", cyc, r.dv_cyc);
          if (r.we) begin
            exp_d = '0;
            if (!e) begin
              cur = model[w];
              for (int i = 0; i < 4; i++)
                if (r.mask[i]) cur[8*i +: 8] = r.data[8*i +: 8];
              model[w] = cur;
            end
            chk("store_dout", data_out, exp_d);
          end else begin
            exp_d = e ? 32'd0 : model[w];
            chk("load_dout", data_out, exp_d);
          end
`ifdef DMEM_ERR_EN
          chk("error", 32'(error), 32'(e));
`endif
        end
      end else begin
        chk("dout_idle", data_out, 32'd0);
      end
    end
  end

  // Drive one request from a negedge; hold it until accepted, then hammer junk while busy.
  task automatic issue(input logic we, input logic [3:0] m, input logic [31:0] a,
                       input logic [31:0] d, input bit track);
    int unsigned n;
    req_t        r;
    request = 1'b1;
    we_re   = we;
    mask    = m;
    address = a;
    data_in = d;
    n = 0;
    while (!valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!valid) begin
      chk("accept_timeout", 32'(valid), 32'd1);
      request = 1'b0;
      return;
    end
    r.we     = we;
    r.mask   = m;
    r.addr   = a;
    r.data   = d;
    r.dv_cyc = cyc + LAT;
    if (track) exp_q.push_back(r);
    @(negedge clk);
    if (!track) return;
    n = 0;
    while (!valid && n < 40) begin
      request = 1'($urandom);
      we_re   = 1'($urandom);
      mask    = 4'($urandom);
      address = $urandom;
      data_in = $urandom;
      @(negedge clk);
      n++;
    end
    request = 1'b0;
    if (!valid) chk("idle_timeout", 32'(valid), 32'd1);
  endtask

  // Hold reset with a store request asserted; optionally confirm valid returns one cycle later.
  task automatic reset_seq(input int n, input bit wait_valid);
    rst     = 1'b0;
    request = 1'b1;
    we_re   = 1'b1;
    mask    = 4'hF;
    address = 32'h10;
    data_in = 32'hBAD0BAD0;
    exp_q.delete();
    repeat (n) begin
      @(negedge clk);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_dv", 32'(data_valid), 32'd0);
    end
    rst     = 1'b1;
    request = 1'b0;
    if (wait_valid) begin
      @(negedge clk);
      chk("valid_after_rst", 32'(valid), 32'd1);
    end
  endtask

  logic [31:0] pool [5];

  initial begin : stimulus
    logic [31:0] a;
    pool[0] = 32'h0;
    pool[1] = 32'h10;
    pool[2] = 32'h20;
    pool[3] = 32'h40;
    pool[4] = 32'hFFC;

    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    reset_seq(3, 1'b1);

    foreach (pool[i]) issue(1'b1, 4'hF, pool[i], $urandom, 1'b1);

    // Reset with a store pending on the pins must leave RAM untouched.
    reset_seq(3, 1'b1);
    issue(1'b0, 4'h0, 32'h10, 32'h0, 1'b1);

    issue(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b1);
    issue(1'b0, 4'hF, 32'h10, 32'h0, 1'b1);

    issue(1'b1, 4'hF, 32'h20, 32'h11223344, 1'b1);
    issue(1'b1, 4'b0010, 32'h20, 32'h0000AA00, 1'b1);
    issue(1'b0, 4'h0, 32'h20, 32'h0, 1'b1);

    // Request raised while valid is low must be held and accepted once valid rises.
    reset_seq(2, 1'b0);
    issue(1'b0, 4'hF, 32'h20, 32'h0, 1'b1);

    issue(1'b1, 4'hF, 32'h40, 32'h55555555, 1'b0);
    reset_seq(2, 1'b1);
    issue(1'b0, 4'hF, 32'h40, 32'h0, 1'b1);

    issue(1'b0, 4'hF, 32'h1010, 32'h0, 1'b1);
    issue(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 1'b1);
    issue(1'b0, 4'hF, 32'h20, 32'h0, 1'b1);

    for (int k = 0; k < 200; k++) begin
      a = pool[$urandom_range(0, 4)] + 32'($urandom_range(0, 3)) * 32'd4096
          + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) a = a & 32'h0000_0FFF;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(1'($urandom), 4'($urandom), a, $urandom, 1'b1);
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
